counter_multi: RTL and testbench
================================

Name: counter_multi

Overview:
- Multi-channel, parametrised successor to the single-channel 32-bit increment counter.
- N_CH independent accumulators, each with its own increment, enable, synchronous load, modulus and wrap mode.
- Adds a wrap pulse, single-shot termination and a done flag.
- Sits next to the timing/sequence generators as a bank of phase/event counters clocked at 100 MHz.

Parameters:
- WIDTH, 32, bit width of each counter, increment, modulus and load value.
- N_CH, 4, number of independent channels.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en_i  input  N_CH  per-channel count enable.
- incr_i  input  N_CH*WIDTH  per-channel increment; channel k occupies bits [k*WIDTH +: WIDTH].
- mod_i  input  N_CH*WIDTH  per-channel modulus; 0 means 2^WIDTH.
- mode_i  input  N_CH*2  per-channel mode: 00 free-run, 01 modulo, 10 single-shot, 11 hold.
- load_i  input  N_CH  per-channel synchronous load strobe.
- load_val_i  input  N_CH*WIDTH  per-channel load value.
- counter_o  output  N_CH*WIDTH  registered counter values.
- wrap_o  output  N_CH  one-cycle pulse per channel on wrap or on single-shot termination.
- done_o  output  N_CH  per-channel single-shot done flag (level).

Behaviour:
- Reset (reset=1 at a rising edge), all channels:
  - counter_o=0, wrap_o=0, done_o=0, channel state RUN.
  - Reset overrides all other inputs.
- All outputs are registered; a change on any input is visible on counter_o one cycle later (latency 1).
- Per-channel priority, highest first:
  - reset
  - load_i: counter<=load_val_i, state<=RUN, done<=0, wrap<=0; applies in any mode, including while DONE.
  - mode 11 or en_i=0: counter holds, wrap<=0.
  - Otherwise count as below.
- Arithmetic: sum = counter + incr computed in WIDTH+1 bits; M = mod_i, with M=0 interpreted as 2^WIDTH.
- Mode 00 free-run:
  - counter<=sum[WIDTH-1:0].
  - wrap<=sum[WIDTH], i.e. a pulse on unsigned carry out.
  - mod_i is ignored.
- Mode 01 modulo:
  - If sum>=M: counter<=sum-M and wrap<=1; else counter<=sum and wrap<=0.
  - Only one subtraction per cycle. If incr>=M, or a loaded value is >=M, the result is sum-M truncated to WIDTH bits with no further correction. Benches must not rely on values outside [0,M-1] under those conditions.
- Mode 10 single-shot, per-channel state machine RUN/DONE:
  - RUN: if sum>=M, then counter<=M-1, wrap<=1 for one cycle, done<=1, state<=DONE. Else counter<=sum.
  - DONE: counter holds, en_i is ignored, done stays 1, wrap=0. Exit only via load_i or reset.
- Changing mode_i mid-count:
  - Takes effect on the next edge, no reset of the counter.
  - Leaving mode 10 while DONE clears done_o and returns the channel to RUN.
- Channels are fully independent: there are no shared carries and simultaneous events on different channels never interact.
- wrap_o is never asserted for two consecutive cycles unless the channel wraps on consecutive counts.

Test Plan:
- Ch0 mode 00, incr=2, en=1 for 5 cycles after reset, then incr=4 for 5 cycles -> counter_o[0] = 2,4,6,8,10 then 14,18,22,26,30; wrap_o=0 throughout; other channels (en=0) stay 0.
- Ch1 mode 00, load 0xFFFFFFFE, incr=3 -> next value 0x00000001 with wrap_o[1]=1 for exactly one cycle.
- Ch2 mode 01, M=10, incr=4, from 0 -> 4,8,2(wrap),6,0(wrap),4; wrap_o[2] high only on the cycles producing 2 and 0.
- Ch3 mode 10, M=7, incr=3 -> 3,6,6(wrap, done_o=1); further en_i has no effect; load_i with val 0 -> counter 0, done_o 0, counting resumes 3,6.
- Simultaneous load_i and en_i on ch0 (val 100, incr 5) -> counter 100, not 105; next cycle 105.
- Assert reset mid-count with en_i, load_i and DONE states active on all channels -> next cycle all counters 0, wrap_o=0, done_o=0; counting resumes the cycle after reset drops.

Source files
------------

// File: rtl/counter_multi.sv
// rtl/counter_multi.sv - bank of independent counters with free-run, modulo, single-shot and hold modes
module counter_multi #(
  parameter int WIDTH = 32,
  parameter int N_CH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH-1:0]        en_i,
  input  logic [N_CH*WIDTH-1:0]  incr_i,
  input  logic [N_CH*WIDTH-1:0]  mod_i,
  input  logic [N_CH*2-1:0]      mode_i,
  input  logic [N_CH-1:0]        load_i,
  input  logic [N_CH*WIDTH-1:0]  load_val_i,
  output logic [N_CH*WIDTH-1:0]  counter_o,
  output logic [N_CH-1:0]        wrap_o,
  output logic [N_CH-1:0]        done_o
);

  typedef enum logic {RUN = 1'b0, DONE = 1'b1} ch_state_t;

  localparam logic [1:0] MODE_FREE = 2'b00;
  localparam logic [1:0] MODE_MOD  = 2'b01;
  localparam logic [1:0] MODE_SHOT = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] incr, modv, ld_val, cnt_minus_m, m_last;
    logic [1:0]       mode;
    logic [WIDTH:0]   sum, m_ext;
    logic             wrap_q, wrap_d, reached;
    ch_state_t        state_q, state_d;

    assign incr   = incr_i[k*WIDTH +: WIDTH];
    assign modv   = mod_i[k*WIDTH +: WIDTH];
    assign ld_val = load_val_i[k*WIDTH +: WIDTH];
    assign mode   = mode_i[k*2 +: 2];

    // A zero modulus stands for 2^WIDTH, so the compare is done one bit wider.
    assign sum         = {1'b0, cnt_q} + {1'b0, incr};
    assign m_ext       = (modv == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, modv};
    assign reached     = (sum >= m_ext);
    assign cnt_minus_m = sum[WIDTH-1:0] - modv;
    assign m_last      = modv - WIDTH'(1);

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q   <= '0;
        wrap_q  <= 1'b0;
        state_q <= RUN;
      end else begin
        cnt_q   <= cnt_d;
        wrap_q  <= wrap_d;
        state_q <= state_d;
      end
    end

    always_comb begin
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      state_d = state_q;
      if (load_i[k]) begin
        cnt_d   = ld_val;
        state_d = RUN;
      end else begin
        // Leaving single-shot releases a finished channel.
        if (mode != MODE_SHOT) state_d = RUN;
        if (mode != MODE_HOLD && en_i[k] && !(mode == MODE_SHOT && state_q == DONE)) begin
          case (mode)
            MODE_FREE: begin
              cnt_d  = sum[WIDTH-1:0];
              wrap_d = sum[WIDTH];
            end
            MODE_MOD: begin
              cnt_d  = reached ? cnt_minus_m : sum[WIDTH-1:0];
              wrap_d = reached;
            end
            MODE_SHOT: begin
              if (reached) begin
                cnt_d   = m_last;
                wrap_d  = 1'b1;
                state_d = DONE;
              end else begin
                cnt_d = sum[WIDTH-1:0];
              end
            end
            default: cnt_d = cnt_q;
          endcase
        end
      end
    end

    assign counter_o[k*WIDTH +: WIDTH] = cnt_q;
    assign wrap_o[k]                   = wrap_q;
    assign done_o[k]                   = (state_q == DONE);
  end

endmodule

// File: tb/tb_counter_multi.sv
// tb/tb_counter_multi.sv - randomized and directed bench for counter_multi against an arithmetic model
module tb_counter_multi;

  localparam int W = 32;
  localparam int N = 4;

  bit              clk;
  logic            reset;
  logic [N-1:0]    en_i, load_i;
  logic [N*W-1:0]  incr_i, mod_i, load_val_i;
  logic [N*2-1:0]  mode_i;
  logic [N*W-1:0]  counter_o;
  logic [N-1:0]    wrap_o, done_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  counter_multi #(.WIDTH(W), .N_CH(N)) dut (
    .clk(clk), .reset(reset), .en_i(en_i), .incr_i(incr_i), .mod_i(mod_i),
    .mode_i(mode_i), .load_i(load_i), .load_val_i(load_val_i),
    .counter_o(counter_o), .wrap_o(wrap_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         wrap;
    logic         done;
  } ch_t;

  ch_t m_st [N];

  // Reference: plain 64-bit arithmetic, modulus 0 read as 2^32.
  function automatic ch_t model_next(ch_t cur, logic rst, logic en, logic ld,
                                     logic [W-1:0] ldv, logic [W-1:0] inc,
                                     logic [W-1:0] modv, logic [1:0] mode);
    ch_t n;
    longint unsigned s, m, r;
    n = cur;
    n.wrap = 1'b0;
    if (rst) return '0;
    if (ld) begin
      n.cnt  = ldv;
      n.done = 1'b0;
      return n;
    end
    if (mode != 2'b10) n.done = 1'b0;
    if (mode == 2'b11 || !en) return n;
    s = longint'(cur.cnt) + longint'(inc);
    m = (modv == 0) ? 64'h1_0000_0000 : longint'(modv);
    case (mode)
      2'b00: begin
        n.cnt  = s[W-1:0];
        n.wrap = (s >= 64'h1_0000_0000);
      end
      2'b01: begin
        r = (s >= m) ? s - m : s;
        n.cnt  = r[W-1:0];
        n.wrap = (s >= m);
      end
      default: begin
        if (!cur.done) begin
          r = (s >= m) ? m - 1 : s;
          n.cnt = r[W-1:0];
          if (s >= m) begin
            n.wrap = 1'b1;
            n.done = 1'b1;
          end
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < N; k++)
      m_st[k] <= model_next(m_st[k], reset, en_i[k], load_i[k], load_val_i[k*W +: W],
                            incr_i[k*W +: W], mod_i[k*W +: W], mode_i[k*2 +: 2]);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        total++;
        if ({counter_o[k*W +: W], wrap_o[k], done_o[k]} !== m_st[k]) begin
          bad++;
          $display("FAIL model_ch%0d t=%0t got cnt=%h wrap=%b done=%b want cnt=%h wrap=%b done=%b",
                   k, $time, counter_o[k*W +: W], wrap_o[k], done_o[k],
                   m_st[k].cnt, m_st[k].wrap, m_st[k].done);
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(string name, logic [W-1:0] got, logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] cnt(int k);
    return counter_o[k*W +: W];
  endfunction

  task automatic set_ch(int k, logic [1:0] md, logic [W-1:0] inc, logic [W-1:0] m);
    mode_i[k*2 +: 2] = md;
    incr_i[k*W +: W] = inc;
    mod_i[k*W +: W]  = m;
  endtask

  function automatic logic [W-1:0] in_range(logic [W-1:0] m);
    return (m == 0) ? $urandom : $urandom_range(0, m - 1);
  endfunction

  int          e3 [6] = '{4, 8, 2, 6, 0, 4};
  int          w3 [6] = '{0, 0, 1, 0, 1, 0};
  int          e4 [3] = '{3, 6, 6};
  int          f4 [3] = '{0, 0, 1};
  logic [1:0]  base [N];
  logic [W-1:0] mv  [N];
  logic [1:0]  alt_modes [3] = '{2'b00, 2'b10, 2'b11};

  initial begin
    reset = 1; en_i = 0; incr_i = 0; mod_i = 0; mode_i = 0; load_i = 0; load_val_i = 0;
    chk_en = 1;
    cyc(); cyc();
    for (int k = 0; k < N; k++) check("reset_cnt", cnt(k), 0);
    check("reset_wrap", 32'(wrap_o), 0);
    check("reset_done", 32'(done_o), 0);
    reset = 0;

    set_ch(0, 2'b00, 2, 0);
    en_i[0] = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("free_inc2", cnt(0), 32'(2 * (i + 1)));
      check("free_nowrap", 32'(wrap_o[0]), 0);
    end
    incr_i[0 +: W] = 4;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("free_inc4", cnt(0), 32'(10 + 4 * (i + 1)));
    end
    en_i[0] = 0;
    for (int k = 1; k < N; k++) check("idle_ch", cnt(k), 0);

    set_ch(1, 2'b00, 3, 0);
    load_i[1] = 1; load_val_i[1*W +: W] = 32'hFFFF_FFFE;
    cyc();
    check("load_ffe", cnt(1), 32'hFFFF_FFFE);
    load_i[1] = 0; en_i[1] = 1;
    cyc();
    check("carry_cnt", cnt(1), 1);
    check("carry_wrap", 32'(wrap_o[1]), 1);
    en_i[1] = 0;
    cyc();
    check("carry_wrap_once", 32'(wrap_o[1]), 0);

    set_ch(2, 2'b01, 4, 10);
    load_i[2] = 1; load_val_i[2*W +: W] = 0;
    cyc();
    load_i[2] = 0; en_i[2] = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("mod_cnt", cnt(2), 32'(e3[i]));
      check("mod_wrap", 32'(wrap_o[2]), 32'(w3[i]));
    end
    en_i[2] = 0;

    set_ch(3, 2'b10, 3, 7);
    load_i[3] = 1; load_val_i[3*W +: W] = 0;
    cyc();
    load_i[3] = 0; en_i[3] = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("shot_cnt", cnt(3), 32'(e4[i]));
      check("shot_wrap", 32'(wrap_o[3]), 32'(f4[i]));
      check("shot_done", 32'(done_o[3]), 32'(f4[i]));
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("done_hold_cnt", cnt(3), 6);
      check("done_hold_wrap", 32'(wrap_o[3]), 0);
      check("done_hold_done", 32'(done_o[3]), 1);
    end
    load_i[3] = 1;
    cyc();
    check("reload_cnt", cnt(3), 0);
    check("reload_done", 32'(done_o[3]), 0);
    load_i[3] = 0;
    cyc(); check("resume_3", cnt(3), 3);
    cyc(); check("resume_6", cnt(3), 6);

    set_ch(0, 2'b00, 5, 0);
    load_i[0] = 1; load_val_i[0 +: W] = 100; en_i[0] = 1;
    cyc(); check("load_beats_en", cnt(0), 100);
    load_i[0] = 0;
    cyc(); check("after_load", cnt(0), 105);

    en_i = '1;
    cyc(); check("pre_reset_done", 32'(done_o[3]), 1);
    load_i[0] = 1; load_val_i[0 +: W] = 7; reset = 1;
    cyc();
    for (int k = 0; k < N; k++) check("midreset_cnt", cnt(k), 0);
    check("midreset_wrap", 32'(wrap_o), 0);
    check("midreset_done", 32'(done_o), 0);
    reset = 0; load_i = 0; en_i = 4'b0001;
    cyc(); check("post_reset", cnt(0), 5);

    for (int p = 0; p < 20; p++) begin
      for (int k = 0; k < N; k++) begin
        base[k] = 2'($urandom_range(0, 2));
        mv[k]   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20);
        set_ch(k, base[k], (base[k] == 2'b00) ? $urandom : in_range(mv[k]), mv[k]);
        load_i[k] = 1;
        load_val_i[k*W +: W] = (base[k] == 2'b00) ? $urandom : in_range(mv[k]);
      end
      cyc();
      load_i = 0;
      for (int c = 0; c < 30; c++) begin
        reset = ($urandom_range(0, 99) == 0);
        for (int k = 0; k < N; k++) begin
          en_i[k]   = ($urandom_range(0, 3) != 0);
          load_i[k] = ($urandom_range(0, 19) == 0);
          load_val_i[k*W +: W] = (base[k] == 2'b00) ? $urandom : in_range(mv[k]);
          if ($urandom_range(0, 9) == 0)
            mode_i[k*2 +: 2] = (base[k] == 2'b01) ? 2'b11 : alt_modes[$urandom_range(0, 2)];
          else
            mode_i[k*2 +: 2] = base[k];
        end
        cyc();
      end
      reset = 0;
    end

    cyc();
    #1;
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
